// File: rtl/router_ingress_if.sv
// Source/FIFO-side bundle of the router ingress controller.
// master: the packet source plus the three output FIFOs (drives byte stream and FIFO flags).
// slave:  the ingress controller itself.
interface router_ingress_if;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic [7:0] dout;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic       busy;
    logic       parity_done;
    logic       err;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
        input  dout, write_enb, lfd_state, busy, parity_done, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
        output dout, write_enb, lfd_state, busy, parity_done, err
    );
endinterface

// File: rtl/router_ingress.sv
// Ingress controller of the 1x3 router: decodes the header byte {len, addr},
// steers the packet into one FIFO, tracks running XOR parity and flags
// parity/length errors. Backpressure to the source is through busy.
module router_ingress #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned LEN_W     = 6
) (
    input  logic            clk,
    input  logic            reset,
    router_ingress_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_EMPTY   = 3'd1,
        LFD          = 3'd2,
        LOAD_DATA    = 3'd3,
        CHECK_PARITY = 3'd4,
        DROP         = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             addr_q, addr_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             hdr_q, hdr_d;
    logic [7:0]             par_q, par_d;
    logic [7:0]             dout_q, dout_d;
    logic [NUM_PORTS-1:0]   write_enb_q, write_enb_d;
    logic                   lfd_state_q, lfd_state_d;
    logic                   parity_done_q, parity_done_d;
    logic                   err_q, err_d;
    logic                   len_err_q, len_err_d;

    logic [NUM_PORTS-1:0]   addr_sel;
    logic [NUM_PORTS-1:0]   hdr_sel;
    logic                   tgt_full;
    logic                   tgt_empty;
    logic                   tgt_soft_reset;
    logic                   stall;
    logic                   busy;

    // One-hot port select; an address beyond the last port selects nothing.
    function automatic logic [NUM_PORTS-1:0] port_sel(input logic [1:0] a);
        port_sel = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (32'(a) == i) port_sel[i] = 1'b1;
        end
    endfunction

    // Per-port flags reduced to the port currently being loaded.
    always_comb begin
        addr_sel       = port_sel(addr_q);
        hdr_sel        = port_sel(bus.data_in[1:0]);
        tgt_full       = |(bus.fifo_full  & addr_sel);
        tgt_empty      = |(bus.fifo_empty & addr_sel);
        tgt_soft_reset = |(bus.soft_reset & addr_sel);
        stall          = |(write_enb_q & addr_sel) & tgt_full;
        busy           = (state_q inside {WAIT_EMPTY, LFD, CHECK_PARITY}) || stall;
    end

    // Next-state and datapath update; a byte is consumed only when busy is low.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        hdr_d         = hdr_q;
        par_d         = par_q;
        dout_d        = dout_q;
        err_d         = err_q;
        len_err_d     = len_err_q;
        lfd_state_d   = 1'b0;
        parity_done_d = 1'b0;
        // A pending write either retries (FIFO full) or completes at this edge.
        write_enb_d   = stall ? write_enb_q : '0;

        unique case (state_q)
            IDLE: begin
                if (bus.pkt_valid) begin
                    if (|hdr_sel) begin
                        addr_d    = bus.data_in[1:0];
                        len_d     = bus.data_in[LEN_W+1:2];
                        cnt_d     = '0;
                        hdr_d     = bus.data_in;
                        par_d     = bus.data_in;
                        err_d     = 1'b0;
                        len_err_d = 1'b0;
                        if (|(bus.fifo_empty & hdr_sel)) begin
                            state_d     = LFD;
                            lfd_state_d = 1'b1;
                        end else begin
                            state_d = WAIT_EMPTY;
                        end
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            WAIT_EMPTY: begin
                if (tgt_empty) begin
                    state_d     = LFD;
                    lfd_state_d = 1'b1;
                end
            end
            LFD: begin
                state_d     = LOAD_DATA;
                dout_d      = hdr_q;
                write_enb_d = addr_sel;
            end
            LOAD_DATA: begin
                if (!stall) begin
                    if (bus.pkt_valid) begin
                        if (cnt_q < len_q) begin
                            dout_d      = bus.data_in;
                            write_enb_d = addr_sel;
                            cnt_d       = cnt_q + LEN_W'(1);
                            par_d       = par_q ^ bus.data_in;
                        end else begin
                            len_err_d = 1'b1;
                        end
                    end else begin
                        dout_d      = bus.data_in;
                        write_enb_d = addr_sel;
                        state_d     = CHECK_PARITY;
                    end
                end
            end
            CHECK_PARITY: begin
                // dout_q still holds the parity byte until its write completes.
                if (!tgt_full) begin
                    state_d       = IDLE;
                    parity_done_d = 1'b1;
                    err_d         = (dout_q != par_q) | (cnt_q != len_q) | len_err_q;
                end
            end
            DROP: begin
                if (!bus.pkt_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Timeout flush of the target FIFO abandons the packet; err is left alone.
        if (!(state_q inside {IDLE, DROP}) && tgt_soft_reset) begin
            write_enb_d   = '0;
            lfd_state_d   = 1'b0;
            parity_done_d = 1'b0;
            dout_d        = dout_q;
            err_d         = err_q;
            state_d       = bus.pkt_valid ? DROP : IDLE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            hdr_q         <= '0;
            par_q         <= '0;
            dout_q        <= '0;
            write_enb_q   <= '0;
            lfd_state_q   <= 1'b0;
            parity_done_q <= 1'b0;
            err_q         <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            hdr_q         <= hdr_d;
            par_q         <= par_d;
            dout_q        <= dout_d;
            write_enb_q   <= write_enb_d;
            lfd_state_q   <= lfd_state_d;
            parity_done_q <= parity_done_d;
            err_q         <= err_d;
            len_err_q     <= len_err_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.write_enb   = write_enb_q;
    assign bus.lfd_state   = lfd_state_q;
    assign bus.parity_done = parity_done_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy;

endmodule

// File: tb/tb_router_ingress.sv
// Bench for router_ingress: directed packets followed by random ones, each
// judged against a packet-level model of what the target FIFO must receive.
module tb_router_ingress;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    router_ingress_if bus ();

    router_ingress #(.NUM_PORTS(3), .LEN_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Monitor state: every completed FIFO write as {port, byte}, pulse counters.
    logic [9:0] wr_log [$];
    int         pd_cnt = 0;
    int         lfd_cnt = 0;
    int         viol = 0;
    logic [2:0] lfd_next_we = '0;
    logic       lfd_prev = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dout = '0;
    logic [2:0] prev_we = '0;

    // Packet under test and model state.
    logic [7:0] pkt_bytes [0:15];
    int         pkt_n;
    int         sr_base;
    int         wait_viol = 0;
    logic       err_model = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            lfd_prev   <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (bus.write_enb[i] && !bus.fifo_full[i]) wr_log.push_back({2'(i), bus.dout});
            if (bus.parity_done) pd_cnt <= pd_cnt + 1;
            if (bus.lfd_state) lfd_cnt <= lfd_cnt + 1;
            if (lfd_prev) lfd_next_we <= bus.write_enb;
            lfd_prev <= bus.lfd_state;
            viol <= viol
                  + int'(prev_stall && (bus.dout !== prev_dout || bus.write_enb !== prev_we))
                  + int'((|(bus.write_enb & bus.fifo_full)) && !bus.busy)
                  + int'($countones(bus.write_enb) > 1);
            prev_stall <= |(bus.write_enb & bus.fifo_full);
            prev_dout  <= bus.dout;
            prev_we    <= bus.write_enb;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        pkt_n = n;
        pkt_bytes[0] = b0; pkt_bytes[1] = b1; pkt_bytes[2] = b2;
        pkt_bytes[3] = b3; pkt_bytes[4] = b4; pkt_bytes[5] = b5;
    endtask

    // Present pkt_bytes one at a time, advancing only when busy was low.
    task automatic drive(input int stall_pct, input int empty_delay, input int sr_at,
                         input int full_from, input int full_len);
        int idx = 0;
        int cyc = 0;
        bit sr_done = 0;
        bit acc;
        bit done = 0;
        logic [1:0] a = pkt_bytes[0][1:0];
        while (idx < pkt_n && cyc < 3000) begin
            bus.pkt_valid  = (idx < pkt_n - 1);
            bus.data_in    = pkt_bytes[idx];
            bus.fifo_empty = (cyc < empty_delay && a != 2'd3) ? ~(3'b001 << a) : 3'b111;
            bus.fifo_full  = '0;
            if (a != 2'd3 && (($urandom_range(99) < 32'(stall_pct)) ||
                              (cyc >= full_from && cyc < full_from + full_len)))
                bus.fifo_full = 3'b001 << a;
            bus.soft_reset = '0;
            if (!sr_done && idx == sr_at && a != 2'd3) bus.soft_reset = 3'b001 << a;
            @(negedge clk);
            acc = !bus.busy;
            if (idx > 0 && cyc < empty_delay && (!bus.busy || bus.write_enb != 3'b000)) wait_viol++;
            @(posedge clk); #1;
            if (bus.soft_reset != 3'b000 && !sr_done) begin
                sr_done = 1;
                sr_base = wr_log.size();
                check("sr_we_clear", 32'(bus.write_enb), 32'h0);
            end
            if (acc) idx++;
            cyc++;
        end
        check("drive_all_bytes", 32'(idx), 32'(pkt_n));
        bus.pkt_valid = 1'b0; bus.data_in = '0; bus.fifo_full = '0;
        bus.fifo_empty = '1; bus.soft_reset = '0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (!bus.busy && bus.write_enb == 3'b000) done = 1;
            @(posedge clk); #1;
        end
        check("idle_after_pkt", 32'(done), 32'h1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Packet-level expectation: header, first min(n,len) payload bytes, parity byte.
    task automatic run_and_check(input int stall_pct, input int empty_delay, input int sr_at,
                                 input int full_from, input int full_len);
        int base = wr_log.size();
        int pd0 = pd_cnt;
        int lfd0 = lfd_cnt;
        logic [7:0] hdr = pkt_bytes[0];
        logic [1:0] a = hdr[1:0];
        int len = int'(hdr[7:2]);
        int n = pkt_n - 2;
        logic [7:0] pbyte = pkt_bytes[pkt_n - 1];
        logic [7:0] exp_b [0:15];
        logic [7:0] x;
        int w, cnt;
        drive(stall_pct, empty_delay, sr_at, full_from, full_len);
        if (sr_at >= 0) begin
            err_model = 1'b0;
            check("sr_no_writes", 32'(wr_log.size() - sr_base), 32'h0);
            check("sr_no_pdone", 32'(pd_cnt - pd0), 32'h0);
        end else if (a == 2'd3) begin
            check("drop_no_writes", 32'(wr_log.size() - base), 32'h0);
            check("drop_no_pdone", 32'(pd_cnt - pd0), 32'h0);
            check("drop_no_lfd", 32'(lfd_cnt - lfd0), 32'h0);
        end else begin
            w = (n < len) ? n : len;
            x = hdr;
            exp_b[0] = hdr;
            for (int k = 0; k < w; k++) begin
                exp_b[k + 1] = pkt_bytes[k + 1];
                x = x ^ pkt_bytes[k + 1];
            end
            exp_b[w + 1] = pbyte;
            cnt = w + 2;
            err_model = (pbyte != x) || (n != len);
            check("wr_count", 32'(wr_log.size() - base), 32'(cnt));
            for (int k = 0; k < cnt && base + k < wr_log.size(); k++)
                check("wr_byte", 32'(wr_log[base + k]), 32'({a, exp_b[k]}));
            check("pdone_once", 32'(pd_cnt - pd0), 32'h1);
            check("lfd_once", 32'(lfd_cnt - lfd0), 32'h1);
            check("lfd_then_we", 32'(lfd_next_we), 32'(3'b001 << a));
        end
        check("err", 32'(bus.err), 32'(err_model));
        check("stall_rules", 32'(viol), 32'h0);
        check("wait_empty_rules", 32'(wait_viol), 32'h0);
    endtask

    task automatic make_rand();
        logic [1:0] a;
        logic [5:0] len;
        int n, r, w;
        logic [7:0] x;
        a   = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
        len = 6'($urandom_range(7));
        r   = int'($urandom_range(9));
        n   = (r == 0) ? int'(len) + 1 : (r == 1 && len > 0) ? int'(len) - 1 : int'(len);
        pkt_bytes[0] = {len, a};
        for (int k = 1; k <= n; k++) pkt_bytes[k] = 8'($urandom);
        w = (n < int'(len)) ? n : int'(len);
        x = pkt_bytes[0];
        for (int k = 1; k <= w; k++) x = x ^ pkt_bytes[k];
        if ($urandom_range(3) == 0) x = x ^ 8'(1 + $urandom_range(254));
        pkt_bytes[n + 1] = x;
        pkt_n = n + 2;
    endtask

    initial begin
        reset = 1'b1;
        bus.pkt_valid = 1'b0; bus.data_in = '0; bus.fifo_full = '0;
        bus.fifo_empty = '1; bus.soft_reset = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_dout", 32'(bus.dout), 32'h0);
        check("rst_we", 32'(bus.write_enb), 32'h0);
        check("rst_lfd", 32'(bus.lfd_state), 32'h0);
        check("rst_pdone", 32'(bus.parity_done), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);

        // Basic packet to port 1.
        load(5, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00);
        run_and_check(0, 0, -1, 0, 0);
        // Bad parity: err set and held.
        load(5, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C, 8'h00);
        run_and_check(0, 0, -1, 0, 0);
        repeat (5) @(posedge clk);
        #1 check("err_held", 32'(bus.err), 32'h1);
        load(5, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00);
        run_and_check(0, 0, -1, 0, 0);
        // Target FIFO not empty at header time.
        load(3, 8'h06, 8'hAA, 8'hAC, 8'h00, 8'h00, 8'h00);
        run_and_check(0, 4, -1, 0, 0);
        // FIFO full for 4 cycles mid-payload.
        load(6, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h14);
        run_and_check(0, 0, -1, 4, 4);
        // Invalid address 3 is dropped.
        load(4, 8'h0B, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00);
        run_and_check(0, 0, -1, 0, 0);
        // Soft reset of the target during payload, then a packet to port 0.
        load(5, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00);
        run_and_check(0, 0, 2, 0, 0);
        load(4, 8'h08, 8'h5A, 8'hA5, 8'hF7, 8'h00, 8'h00);
        run_and_check(0, 0, -1, 0, 0);
        // len=0, overrun, underrun.
        load(2, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        run_and_check(0, 0, -1, 0, 0);
        load(4, 8'h05, 8'h77, 8'h88, 8'h72, 8'h00, 8'h00);
        run_and_check(0, 0, -1, 0, 0);
        load(3, 8'h0E, 8'h99, 8'h97, 8'h00, 8'h00, 8'h00);
        run_and_check(0, 0, -1, 0, 0);

        // Hard reset in the middle of a packet.
        bus.pkt_valid = 1'b1; bus.data_in = 8'h0D;
        @(posedge clk); #1 bus.data_in = 8'h11;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; bus.pkt_valid = 1'b0; bus.data_in = '0;
        err_model = 1'b0;
        check("mid_rst_we", 32'(bus.write_enb), 32'h0);
        check("mid_rst_dout", 32'(bus.dout), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_lfd", 32'(bus.lfd_state), 32'h0);
        load(6, 8'h12, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h12 ^ 8'hC1 ^ 8'hC2 ^ 8'hC3 ^ 8'hC4);
        run_and_check(0, 0, -1, 0, 0);

        // Random packets with random stalls and occasional non-empty targets.
        for (int p = 0; p < 40; p++) begin
            make_rand();
            run_and_check(int'($urandom_range(40)),
                          ($urandom_range(3) == 0) ? 2 + int'($urandom_range(3)) : 0,
                          -1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
